chacha_qr_sequencer: RTL and testbench
======================================

CHACHA_QR_SEQUENCER -- requirements
Module: chacha_qr_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 din  input  8  host write data byte.
REQ-004 addr  input  4  byte address: addr[3:2] selects word (0=a, 1=b, 2=c, 3=d); addr[1:0] selects byte lane (0=bits 7:0 .. 3=bits 31:24).
REQ-005 wr_en  input  1  byte write strobe, one byte per cycle.
REQ-006 start  input  1  single-cycle request to run quarter rounds.
REQ-007 n_qr  input  4  number of quarter rounds to run, sampled only when start is accepted.
REQ-008 dout  output  8  registered read byte at addr.
REQ-009 busy  output  1  high while quarter-round steps execute.
REQ-010 done  output  1  one-cycle completion pulse.

Function
REQ-011 The block SHALL hold four 32-bit state words a, b, c and d.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE->RUN SHALL occur on an edge with start=1; n_qr SHALL be latched and the step counter and QR counter cleared on that edge.
REQ-014 start SHALL be ignored in RUN and DONE.
REQ-015 In IDLE, wr_en=1 SHALL write din into the byte of the word selected by addr on that edge.
REQ-016 wr_en SHALL be ignored in RUN and DONE; the state words SHALL change only through quarter-round steps.
REQ-017 wr_en and start on the same IDLE edge SHALL both take effect; the first step SHALL use the post-write state.
REQ-018 Each RUN edge SHALL execute exactly one step, selected by the 2-bit step counter; all additions SHALL be mod 2^32 and <<< SHALL be a 32-bit left rotate:
 - step 0: a=a+b; d=(d^(a+b))<<<16
 - step 1: c=c+d; b=(b^(c+d))<<<12
 - step 2: a=a+b; d=(d^(a+b))<<<8
 - step 3: c=c+d; b=(b^(c+d))<<<7
REQ-019 The step counter SHALL wrap 3->0; each wrap SHALL increment the QR counter.
REQ-020 The edge that executes step 3 of quarter round n_qr-1 SHALL move RUN->DONE, giving 4*n_qr RUN cycles.
REQ-021 n_qr=0 SHALL move IDLE->DONE directly with no state change.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 On every edge, dout SHALL load the byte addressed by addr from the pre-edge state, giving one-cycle read latency.
REQ-025 Reads SHALL be valid in all states; in RUN, dout SHALL show intermediate values.

Reset
REQ-026 rst_n=0 on an edge SHALL clear a, b, c, d, dout, the step counter, the QR counter and latched n_qr to 0, and force IDLE (busy=0, done=0).
REQ-027 Reset SHALL take priority over wr_en, start and any in-progress step, including in RUN or DONE.

Verification
REQ-028 RFC 7539 2.1.1 vector: load a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567; start with n_qr=1 -> busy high 4 cycles, done pulse 1 cycle, then a=0xea2a92f4, b=0xcb1cf8ce, c=0x4581472e, d=0x5881c4bb.
REQ-029 Read-back and latency: write bytes 0x00..0x0f to addr 0..15; read addr 5 -> dout=0x05 one cycle later; read addr 15 -> dout=0x0f.
REQ-030 Ignored inputs: during RUN, pulse wr_en (addr 0, din 0xff) and start -> result still matches REQ-028; exactly one done pulse.
REQ-031 Boundary counts:
 - n_qr=0 -> done on the cycle after start, state unchanged.
 - n_qr=15 -> 60 busy cycles; result matches a golden model.
REQ-032 Reset mid-RUN: assert rst_n=0 at busy cycle 2 -> all words read 0x00, busy=0, done=0; no done pulse follows.
REQ-033 Write+start same edge: load REQ-028 vector except a's byte 0 (=0x00), then on one edge write din=0x11 to addr 0 and start with n_qr=1 -> result matches REQ-028.

Source files
------------

// File: rtl/chacha_qr_sequencer.sv
// ChaCha quarter-round sequencer: four byte-addressable 32-bit words, updated
// one add/xor/rotate step per clock for a programmable number of quarter rounds.
module chacha_qr_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_din,
   input  logic [3:0] i_addr,
   input  logic       i_wr_en,
   input  logic       i_start,
   input  logic [3:0] i_n_qr,
   output logic [7:0] o_dout,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_a, r_b, r_c, r_d;
   logic [1:0]  r_step;
   logic [3:0]  r_qr;
   logic [3:0]  r_nqr;
   logic [7:0]  r_dout;

   logic [31:0] w_sumAb, w_sumCd, w_xorD, w_xorB;
   logic [31:0] w_rdWord;
   logic        w_lastStep;

   assign w_sumAb    = r_a + r_b;
   assign w_sumCd    = r_c + r_d;
   assign w_xorD     = r_d ^ w_sumAb;
   assign w_xorB     = r_b ^ w_sumCd;
   assign w_lastStep = (r_step == 2'd3) && (r_qr == (r_nqr - 4'd1));

   always_comb begin
      w_rdWord = r_a;
      case (i_addr[3:2])
         2'd0: w_rdWord = r_a;
         2'd1: w_rdWord = r_b;
         2'd2: w_rdWord = r_c;
         2'd3: w_rdWord = r_d;
         default: w_rdWord = r_a;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = (i_n_qr == 4'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_lastStep) begin
               w_next = DONE;
            end
         end
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Reads sample the pre-edge words, so a write lands one cycle before it is visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= '0;
         r_d    <= '0;
         r_step <= '0;
         r_qr   <= '0;
         r_nqr  <= '0;
         r_dout <= '0;
      end else begin
         r_dout <= w_rdWord[{i_addr[1:0], 3'b000} +: 8];
         case (r_state)
            IDLE: begin
               if (i_wr_en) begin
                  case (i_addr[3:2])
                     2'd0: r_a[{i_addr[1:0], 3'b000} +: 8] <= i_din;
                     2'd1: r_b[{i_addr[1:0], 3'b000} +: 8] <= i_din;
                     2'd2: r_c[{i_addr[1:0], 3'b000} +: 8] <= i_din;
                     2'd3: r_d[{i_addr[1:0], 3'b000} +: 8] <= i_din;
                     default: ;
                  endcase
               end
               if (i_start) begin
                  r_nqr  <= i_n_qr;
                  r_step <= '0;
                  r_qr   <= '0;
               end
            end
            RUN: begin
               case (r_step)
                  2'd0: begin
                     r_a <= w_sumAb;
                     r_d <= {w_xorD[15:0], w_xorD[31:16]};
                  end
                  2'd1: begin
                     r_c <= w_sumCd;
                     r_b <= {w_xorB[19:0], w_xorB[31:20]};
                  end
                  2'd2: begin
                     r_a <= w_sumAb;
                     r_d <= {w_xorD[23:0], w_xorD[31:24]};
                  end
                  default: begin
                     r_c <= w_sumCd;
                     r_b <= {w_xorB[24:0], w_xorB[31:25]};
                  end
               endcase
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) begin
                  r_qr <= r_qr + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dout = r_dout;
   assign o_busy = (r_state == RUN);
   assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_chacha_qr_sequencer.sv
// Directed self-checking bench for chacha_qr_sequencer using RFC 7539 vectors
// and a reference quarter-round function for long runs.
module tb_chacha_qr_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_din;
   logic [3:0] i_addr;
   logic       i_wr_en;
   logic       i_start;
   logic [3:0] i_n_qr;
   logic [7:0] o_dout;
   logic       o_busy;
   logic       o_done;

   int nChecks = 0;
   int nPass   = 0;

   chacha_qr_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_din   (i_din),
      .i_addr  (i_addr),
      .i_wr_en (i_wr_en),
      .i_start (i_start),
      .i_n_qr  (i_n_qr),
      .o_dout  (o_dout),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Reference quarter round in the textbook form.
   task automatic refQr(inout logic [31:0] a, inout logic [31:0] b,
                        inout logic [31:0] c, inout logic [31:0] d);
      a = a + b; d = d ^ a; d = rotl(d, 16);
      c = c + d; b = b ^ c; b = rotl(b, 12);
      a = a + b; d = d ^ a; d = rotl(d, 8);
      c = c + d; b = b ^ c; b = rotl(b, 7);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) begin
         nPass++;
      end else begin
         $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [7:0] d,
                                input logic st, input logic [3:0] n);
      i_wr_en = wr;
      i_addr  = a;
      i_din   = d;
      i_start = st;
      i_n_qr  = n;
      @(posedge clk);
      #1;
      i_wr_en = 1'b0;
      i_start = 1'b0;
   endtask

   task automatic writeWord(input logic [1:0] sel, input logic [31:0] w);
      for (int lane = 0; lane < 4; lane++) begin
         applyStimulus(1'b1, {sel, lane[1:0]}, w[8*lane +: 8], 1'b0, 4'd0);
      end
   endtask

   task automatic readWord(input logic [1:0] sel, output logic [31:0] w);
      for (int lane = 0; lane < 4; lane++) begin
         applyStimulus(1'b0, {sel, lane[1:0]}, 8'h00, 1'b0, 4'd0);
         w[8*lane +: 8] = o_dout;
      end
   endtask

   task automatic loadState(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
      writeWord(2'd0, a);
      writeWord(2'd1, b);
      writeWord(2'd2, c);
      writeWord(2'd3, d);
   endtask

   task automatic checkState(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
      logic [31:0] w;
      readWord(2'd0, w); checkOutput({tag, ".a"}, w, a);
      readWord(2'd1, w); checkOutput({tag, ".b"}, w, b);
      readWord(2'd2, w); checkOutput({tag, ".c"}, w, c);
      readWord(2'd3, w); checkOutput({tag, ".d"}, w, d);
   endtask

   // Start a run and watch a fixed window; optionally poke wr_en/start mid-run.
   task automatic runQr(input logic [3:0] n, input logic inject,
                        input logic firstWr, input logic [7:0] firstDin,
                        output int busyCnt, output int doneCnt, output int doneIdx);
      busyCnt = 0;
      doneCnt = 0;
      doneIdx = -1;
      applyStimulus(firstWr, 4'd0, firstDin, 1'b1, n);
      for (int i = 0; i < 4 * int'(n) + 6; i++) begin
         if (o_busy) busyCnt++;
         if (o_done) begin
            doneCnt++;
            if (doneIdx < 0) doneIdx = i;
         end
         if (inject && i == 1) applyStimulus(1'b1, 4'd0, 8'hff, 1'b1, 4'd3);
         else                  applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      end
   endtask

   localparam logic [31:0] VA = 32'h11111111, VB = 32'h01020304,
                           VC = 32'h9b8d6f43, VD = 32'h01234567;
   localparam logic [31:0] RA = 32'hea2a92f4, RB = 32'hcb1cf8ce,
                           RC = 32'h4581472e, RD = 32'h5881c4bb;

   initial begin
      int busyCnt, doneCnt, doneIdx;
      logic [31:0] w, ga, gb, gc, gd;

      rst_n = 1'b0; i_din = '0; i_addr = '0; i_wr_en = 1'b0; i_start = 1'b0; i_n_qr = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.busy", {31'd0, o_busy}, 32'd0);
      checkOutput("reset.done", {31'd0, o_done}, 32'd0);
      checkOutput("reset.dout", {24'd0, o_dout}, 32'd0);
      rst_n = 1'b1;
      checkState("reset", 32'd0, 32'd0, 32'd0, 32'd0);

      $display("[TB] RFC 7539 quarter-round vector");
      loadState(VA, VB, VC, VD);
      runQr(4'd1, 1'b0, 1'b0, 8'h00, busyCnt, doneCnt, doneIdx);
      checkOutput("rfc.busyCycles", busyCnt, 32'd4);
      checkOutput("rfc.donePulses", doneCnt, 32'd1);
      checkOutput("rfc.doneIdx", doneIdx, 32'd4);
      checkState("rfc", RA, RB, RC, RD);

      $display("[TB] byte read-back");
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, k[3:0], k[7:0], 1'b0, 4'd0);
      applyStimulus(1'b0, 4'd5, 8'h00, 1'b0, 4'd0);
      checkOutput("read.addr5", {24'd0, o_dout}, 32'h05);
      applyStimulus(1'b0, 4'd15, 8'h00, 1'b0, 4'd0);
      checkOutput("read.addr15", {24'd0, o_dout}, 32'h0f);
      readWord(2'd2, w);
      checkOutput("read.wordC", w, 32'h0b0a0908);

      $display("[TB] wr_en/start ignored while running");
      loadState(VA, VB, VC, VD);
      runQr(4'd1, 1'b1, 1'b0, 8'h00, busyCnt, doneCnt, doneIdx);
      checkOutput("ignore.busyCycles", busyCnt, 32'd4);
      checkOutput("ignore.donePulses", doneCnt, 32'd1);
      checkState("ignore", RA, RB, RC, RD);

      $display("[TB] n_qr = 0");
      loadState(VA, VB, VC, VD);
      runQr(4'd0, 1'b0, 1'b0, 8'h00, busyCnt, doneCnt, doneIdx);
      checkOutput("nqr0.busyCycles", busyCnt, 32'd0);
      checkOutput("nqr0.donePulses", doneCnt, 32'd1);
      checkOutput("nqr0.doneIdx", doneIdx, 32'd0);
      checkState("nqr0", VA, VB, VC, VD);

      $display("[TB] n_qr = 15 against reference model");
      ga = VA; gb = VB; gc = VC; gd = VD;
      for (int q = 0; q < 15; q++) refQr(ga, gb, gc, gd);
      loadState(VA, VB, VC, VD);
      runQr(4'd15, 1'b0, 1'b0, 8'h00, busyCnt, doneCnt, doneIdx);
      checkOutput("nqr15.busyCycles", busyCnt, 32'd60);
      checkOutput("nqr15.donePulses", doneCnt, 32'd1);
      checkState("nqr15", ga, gb, gc, gd);

      $display("[TB] reset during run");
      loadState(VA, VB, VC, VD);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd1);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      checkOutput("midrst.busyBefore", {31'd0, o_busy}, 32'd1);
      rst_n = 1'b0;
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      rst_n = 1'b1;
      checkOutput("midrst.busy", {31'd0, o_busy}, 32'd0);
      checkOutput("midrst.done", {31'd0, o_done}, 32'd0);
      checkOutput("midrst.dout", {24'd0, o_dout}, 32'd0);
      doneCnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (o_done) doneCnt++;
         applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      end
      checkOutput("midrst.noDone", doneCnt, 32'd0);
      checkState("midrst", 32'd0, 32'd0, 32'd0, 32'd0);

      $display("[TB] write and start on the same edge");
      loadState(32'h11111100, VB, VC, VD);
      runQr(4'd1, 1'b0, 1'b1, 8'h11, busyCnt, doneCnt, doneIdx);
      checkOutput("wrstart.busyCycles", busyCnt, 32'd4);
      checkState("wrstart", RA, RB, RC, RD);

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
